// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        StDecide,
        StMove,
        StDoor
    } state_e;

    // Bits needed to hold max(a, b) as an unsigned count.
    function automatic int unsigned clog2_max(input int unsigned a, input int unsigned b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that parks at zero; done flags the zero count.
module tick_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (!done) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Multi-floor elevator controller: latches requests and serves them in SCAN order
// with a timed travel per floor and a timed door dwell at each served floor.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned NUM_FLOORS   = 8,
    parameter int unsigned TRAVEL_TICKS = 10000000,
    parameter int unsigned DOOR_TICKS   = 20000000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_FLOORS-1:0]         req_in,
    output logic [$clog2(NUM_FLOORS)-1:0] current_floor,
    output logic [NUM_FLOORS-1:0]         pending,
    output logic                          dir_up,
    output logic                          moving,
    output logic                          door_open,
    output logic                          idle
);

    localparam int unsigned FLOOR_W = $clog2(NUM_FLOORS);
    localparam int unsigned TIMER_W = clog2_max(TRAVEL_TICKS, DOOR_TICKS);
    localparam logic [TIMER_W-1:0] TRAVEL_LOAD = TIMER_W'(TRAVEL_TICKS - 1);
    localparam logic [TIMER_W-1:0] DOOR_LOAD   = TIMER_W'(DOOR_TICKS - 1);

    state_e                 state_q, state_d;
    logic [FLOOR_W-1:0]     floor_q, floor_d;
    logic [NUM_FLOORS-1:0]  pending_q, pending_d;
    logic                   dir_up_q, dir_up_d;

    logic                   timer_load;
    logic [TIMER_W-1:0]     timer_load_val;
    logic                   timer_done;

    logic [NUM_FLOORS-1:0]  above_mask, below_mask, clr;
    logic                   ahead, behind;

    tick_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .done     (timer_done)
    );

    always_comb begin
        above_mask = '0;
        below_mask = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            above_mask[i] = (i > int'(floor_q));
            below_mask[i] = (i < int'(floor_q));
        end
    end

    assign ahead  = dir_up_q ? |(pending_q & above_mask) : |(pending_q & below_mask);
    assign behind = dir_up_q ? |(pending_q & below_mask) : |(pending_q & above_mask);

    always_comb begin
        state_d        = state_q;
        floor_d        = floor_q;
        dir_up_d       = dir_up_q;
        timer_load     = 1'b0;
        timer_load_val = '0;
        unique case (state_q)
            StDecide: begin
                if (pending_q[floor_q]) begin
                    state_d        = StDoor;
                    timer_load     = 1'b1;
                    timer_load_val = DOOR_LOAD;
                end else if (ahead || behind) begin
                    // Reverse only once nothing remains in the current direction.
                    dir_up_d       = ahead ? dir_up_q : ~dir_up_q;
                    state_d        = StMove;
                    timer_load     = 1'b1;
                    timer_load_val = TRAVEL_LOAD;
                end
            end
            StMove: begin
                if (timer_done) begin
                    floor_d = dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
                    state_d = StDecide;
                end
            end
            StDoor: begin
                if (timer_done) begin
                    state_d = StDecide;
                end
            end
            default: state_d = StDecide;
        endcase
    end

    // The floor being served is cleared on door entry and throughout the dwell.
    always_comb begin
        clr = '0;
        if (state_q == StDoor || state_d == StDoor) begin
            clr[floor_q] = 1'b1;
        end
        pending_d = (pending_q | req_in) & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StDecide;
            floor_q   <= '0;
            pending_q <= '0;
            dir_up_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            dir_up_q  <= dir_up_d;
        end
    end

    assign current_floor = floor_q;
    assign pending       = pending_q;
    assign dir_up        = dir_up_q;
    assign moving        = (state_q == StMove);
    assign door_open     = (state_q == StDoor);
    assign idle          = (state_q == StDecide) && (pending_q == '0);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench: cycle-level behavioural model plus directed literal checks
// and a randomized request phase.
module tb_elevator_scan_ctrl;

    localparam int NF     = 6;
    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    logic          clk;
    logic          rst_n;
    logic [NF-1:0] req_in;
    logic [2:0]    current_floor;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          moving;
    logic          door_open;
    logic          idle;

    int tests = 0;
    int fails = 0;

    elevator_scan_ctrl #(
        .NUM_FLOORS   (NF),
        .TRAVEL_TICKS (TRAVEL),
        .DOOR_TICKS   (DOOR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_in        (req_in),
        .current_floor (current_floor),
        .pending       (pending),
        .dir_up        (dir_up),
        .moving        (moving),
        .door_open     (door_open),
        .idle          (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: car position, pending set, direction, and remaining cycles of travel/door.
    int          m_floor;
    bit [NF-1:0] m_pend;
    bit          m_up;
    int          m_travel_left;
    int          m_door_left;
    bit          m_was_door, m_enter, m_ahead, m_behind;
    bit [NF-1:0] m_clr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_floor       = 0;
            m_pend        = '0;
            m_up          = 1'b1;
            m_travel_left = 0;
            m_door_left   = 0;
        end else begin
            m_was_door = (m_door_left > 0);
            m_enter    = 1'b0;
            if (m_travel_left > 0) begin
                m_travel_left--;
                if (m_travel_left == 0) m_floor = m_up ? m_floor + 1 : m_floor - 1;
            end else if (m_door_left > 0) begin
                m_door_left--;
            end else begin
                m_ahead  = 1'b0;
                m_behind = 1'b0;
                for (int f = 0; f < NF; f++) begin
                    if (m_pend[f] && f != m_floor) begin
                        if ((m_up && f > m_floor) || (!m_up && f < m_floor)) m_ahead = 1'b1;
                        else m_behind = 1'b1;
                    end
                end
                if (m_pend[m_floor]) begin
                    m_door_left = DOOR;
                    m_enter     = 1'b1;
                end else if (m_ahead) begin
                    m_travel_left = TRAVEL;
                end else if (m_behind) begin
                    m_up          = !m_up;
                    m_travel_left = TRAVEL;
                end
            end
            m_clr = '0;
            if (m_was_door || m_enter) m_clr[m_floor] = 1'b1;
            m_pend = (m_pend | req_in) & ~m_clr;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_floor",  32'(current_floor), m_floor);
            check("model_pend",   32'(pending),       32'(m_pend));
            check("model_dir_up", 32'(dir_up),        32'(m_up));
            check("model_moving", 32'(moving),        32'(m_travel_left > 0));
            check("model_door",   32'(door_open),     32'(m_door_left > 0));
            check("model_idle",   32'(idle),
                  32'(m_travel_left == 0 && m_door_left == 0 && m_pend == '0));
        end
    end

    int door_log[$];
    bit door_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n && door_open && !door_prev) door_log.push_back(int'(current_floor));
        door_prev = door_open && rst_n;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [NF-1:0] mask);
        req_in = mask;
        tick(1);
        req_in = '0;
    endtask

    task automatic do_reset();
        req_in = '0;
        rst_n  = 1'b0;
        tick(2);
        rst_n  = 1'b1;
        tick(1);
        door_log.delete();
    endtask

    task automatic wait_floor(input int f, input int budget);
        int n = 0;
        while (int'(current_floor) != f && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_floor", 32'(current_floor), f);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!idle && n < budget) begin
            tick(1);
            n++;
        end
        check("wait_idle", 32'(idle), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        req_in = '0;
        do_reset();
        check("rst_floor",  32'(current_floor), 0);
        check("rst_pend",   32'(pending), 0);
        check("rst_dir_up", 32'(dir_up), 1);
        check("rst_moving", 32'(moving), 0);
        check("rst_door",   32'(door_open), 0);
        check("rst_idle",   32'(idle), 1);

        // Single request to floor 3: 5 cycles per floor, 3-cycle dwell.
        pulse(6'b001000);
        check("s1_pend_latched", 32'(pending), 32'h08);
        check("s1_not_yet_moving", 32'(moving), 0);
        tick(1);
        check("s1_moving", 32'(moving), 1);
        tick(4);
        check("s1_floor1", 32'(current_floor), 1);
        tick(5);
        check("s1_floor2", 32'(current_floor), 2);
        tick(5);
        check("s1_floor3", 32'(current_floor), 3);
        check("s1_door_not_yet", 32'(door_open), 0);
        tick(1);
        check("s1_door_open", 32'(door_open), 1);
        check("s1_pend_cleared", 32'(pending), 0);
        tick(2);
        check("s1_door_last", 32'(door_open), 1);
        tick(1);
        check("s1_door_closed", 32'(door_open), 0);
        check("s1_idle", 32'(idle), 1);

        // Request at current floor; a repeat during the dwell is absorbed.
        do_reset();
        pulse(6'b000001);
        check("s2_pend", 32'(pending), 32'h01);
        tick(1);
        check("s2_door", 32'(door_open), 1);
        pulse(6'b000001);
        check("s2_absorbed", 32'(pending), 0);
        tick(1);
        check("s2_door_last", 32'(door_open), 1);
        tick(1);
        check("s2_door_closed", 32'(door_open), 0);
        check("s2_idle", 32'(idle), 1);
        check("s2_floor", 32'(current_floor), 0);
        check("s2_door_count", door_log.size(), 1);

        // Moving up past 2 toward 5; add requests at 4 and 0.
        do_reset();
        pulse(6'b100000);
        wait_floor(2, 40);
        pulse(6'b010001);
        wait_idle(200);
        check("s3_door_count", door_log.size(), 3);
        if (door_log.size() == 3) begin
            check("s3_door0", door_log[0], 4);
            check("s3_door1", door_log[1], 5);
            check("s3_door2", door_log[2], 0);
        end
        check("s3_floor", 32'(current_floor), 0);
        check("s3_dir_down", 32'(dir_up), 0);

        // All floors requested from floor 0.
        do_reset();
        pulse(6'b111111);
        wait_idle(200);
        check("s4_door_count", door_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < door_log.size()) check("s4_door_order", door_log[i], i);
        end
        check("s4_floor", 32'(current_floor), 5);
        check("s4_dir_up", 32'(dir_up), 1);
        check("s4_pend", 32'(pending), 0);

        // Asynchronous reset mid-travel between floors 2 and 3.
        do_reset();
        pulse(6'b100000);
        wait_floor(2, 40);
        tick(2);
        check("s5_moving_before", 32'(moving), 1);
        #1 rst_n = 1'b0;
        #1;
        check("s5_floor",  32'(current_floor), 0);
        check("s5_pend",   32'(pending), 0);
        check("s5_moving", 32'(moving), 0);
        check("s5_door",   32'(door_open), 0);
        tick(1);
        rst_n = 1'b1;
        tick(20);
        check("s5_stays_floor", 32'(current_floor), 0);
        check("s5_stays_still", 32'(moving), 0);
        check("s5_idle", 32'(idle), 1);

        // Randomized requests checked cycle-by-cycle against the model.
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) do_reset();
            req_in = ($urandom_range(0, 9) == 0) ? NF'($urandom) : '0;
            tick(1);
        end
        req_in = '0;
        wait_idle(500);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
